dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory (DMEM) between two masters:
  - the CPU MEM stage;
  - a debug/loader master, used for preload, memory dump and inspection while the core runs.
- Grants one access per cycle and stalls the losing CPU request.
- Routes the one-cycle-latency read data back to the master that issued the read.
- Enforces bounded debug wait through a starvation counter and priority-flip state machine.

Parameters:
- ADDR_WIDTH, 8, DMEM word-address width.
- DATA_WIDTH, 16, data word width.
- MAX_WAIT, 4, number of consecutive cycles the debug master may be denied before it takes priority (range 1..15).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU MEM-stage access request.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_WIDTH  CPU word address.
- cpu_wdata  in  DATA_WIDTH  store data.
- cpu_stall  out  1  combinational; holds the pipeline while the CPU request is denied.
- cpu_rvalid  out  1  load data valid.
- cpu_rdata  out  DATA_WIDTH  load data.
- dbg_req  in  1  debug access request; must stay high with stable fields until granted.
- dbg_we  in  1  debug write enable.
- dbg_addr  in  ADDR_WIDTH  debug address.
- dbg_wdata  in  DATA_WIDTH  debug write data.
- dbg_gnt  out  1  combinational; access accepted this cycle.
- dbg_rvalid  out  1  debug read data valid.
- dbg_rdata  out  DATA_WIDTH  debug read data.
- mem_en  out  1  DMEM access strobe.
- mem_we  out  1  DMEM write enable.
- mem_addr  out  ADDR_WIDTH  DMEM address.
- mem_wdata  out  DATA_WIDTH  DMEM write data.
- mem_rdata  in  DATA_WIDTH  DMEM read data; valid the cycle after mem_en && !mem_we.

Behaviour:
- Reset: `reset` low asynchronously clears the following, and they stay at these values while reset is low:
  - state = CPU_PRI, wait_cnt = 0, rd_owner = NONE;
  - cpu_rvalid = dbg_rvalid = 0.
  - cpu_stall follows the combinational rule. It is 0 with no requests.
- Reset mid-read: any read in flight when reset asserts is dropped. No rvalid is produced for it after release.
- Grant (combinational, one winner per cycle):
  - CPU_PRI state: CPU wins if cpu_req; otherwise debug wins if dbg_req.
  - DBG_PRI state: debug wins if dbg_req; otherwise CPU wins.
- Outputs of the grant:
  - mem_en = 1 when any request is present.
  - mem_we, mem_addr and mem_wdata are muxed from the winner.
  - dbg_gnt = debug wins.
  - cpu_stall = cpu_req && !cpu wins.
  - When no request is present: mem_en = 0, mem_we = 0, and addr/wdata are driven to 0.
- Read return (registered):
  - rd_owner <= winner if the winning access is a read, else NONE.
  - Next cycle, cpu_rvalid = (rd_owner == CPU) and dbg_rvalid = (rd_owner == DBG), each for exactly 1 cycle.
  - cpu_rdata and dbg_rdata are both driven from mem_rdata; consumers qualify with their rvalid.
  - Read latency is 1 cycle after grant. Back-to-back grants are allowed every cycle.
- State machine:
  - CPU_PRI:
    - If dbg_req && !dbg_gnt: wait_cnt++.
    - If dbg_gnt, or dbg_req low: wait_cnt <= 0.
    - When wait_cnt == MAX_WAIT-1 and debug is denied again: go to DBG_PRI, wait_cnt <= 0.
  - DBG_PRI:
    - Persists exactly until one debug access is granted, then returns to CPU_PRI.
    - If dbg_req drops before being granted, returns to CPU_PRI next cycle.
- Resulting guarantee: debug waits at most MAX_WAIT+1 cycles. The CPU is stalled for exactly 1 cycle per forced debug access.
- Simultaneous same-address CPU write and debug read: only the winner touches DMEM. The loser retries later and sees the winner's result (no bypass).
- wait_cnt width is 4 bits and saturates, never wraps. This is guaranteed by the MAX_WAIT range.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - owner_t enum {OWN_NONE, OWN_CPU, OWN_DBG};
  - state_t enum {CPU_PRI, DBG_PRI};
  - WAIT_CNT_W = 4 constant.
- One sub-module, arb_starve_ctr: wait counter plus priority-flip FSM. It takes dbg_req and dbg_gnt and outputs dbg_pri.
- Grant mux and read-return tracking stay in the top level.

Test Plan:
- CPU only:
  - Store 0x1234 to address 0x10, then load 0x10 → cpu_stall = 0 throughout.
  - cpu_rvalid = 1 with cpu_rdata = 0x1234 exactly one cycle after the load grant.
- Debug only:
  - dbg write 0xBEEF to 0x20, then dbg read 0x20 → dbg_gnt high the same cycle each time.
  - dbg_rvalid with 0xBEEF one cycle later; cpu_rvalid stays 0.
- Contention, MAX_WAIT = 4:
  - cpu_req held continuously, dbg read of 0x05 held → debug denied 4 cycles, granted on cycle 5.
  - cpu_stall = 1 for exactly that cycle; then CPU_PRI is restored and cpu_stall = 0.
- Interleaved reads:
  - CPU read 0x01 in cycle N, debug read 0x02 in N+1 (CPU idle) → cpu_rvalid at N+1 with mem[0x01].
  - dbg_rvalid at N+2 with mem[0x02]; never both valid the same cycle.
- Debug withdraw:
  - In DBG_PRI, drop dbg_req before the grant → state returns to CPU_PRI next cycle, wait_cnt = 0, no stall.
- Reset mid-read:
  - Assert reset (low) in the cycle after a CPU read grant → cpu_rvalid stays 0, all outputs are at reset values.
  - After release, the first request is handled normally.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the DMEM arbiter: read-return owner,
// priority state and starvation counter width.
package dmem_arb_pkg;

   localparam int WAIT_CNT_W = 4;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_CPU,
      OWN_DBG
   } owner_t;

   typedef enum logic {
      CPU_PRI,
      DBG_PRI
   } state_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Debug starvation counter and priority-flip FSM: after MAX_WAIT consecutive
// denials the debug master holds priority until one of its accesses is granted.
module arb_starve_ctr #(
   parameter int MAX_WAIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic dbg_req,
   input  logic dbg_gnt,
   output logic dbg_pri
);
   import dmem_arb_pkg::*;

   localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MAX_WAIT - 1);

   state_t                 state_q, state_d;
   logic [WAIT_CNT_W-1:0]  wait_q, wait_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= CPU_PRI;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      case (state_q)
         CPU_PRI: begin
            if (dbg_req && !dbg_gnt) begin
               if (wait_q == WAIT_LAST) begin
                  state_d = DBG_PRI;
                  wait_d  = '0;
               end else if (wait_q != '1) begin
                  // saturate rather than wrap if MAX_WAIT is ever misconfigured
                  wait_d = wait_q + WAIT_CNT_W'(1);
               end
            end else begin
               wait_d = '0;
            end
         end
         DBG_PRI: begin
            wait_d = '0;
            if (dbg_gnt || !dbg_req)
               state_d = CPU_PRI;
         end
         default: begin
            state_d = CPU_PRI;
            wait_d  = '0;
         end
      endcase
   end

   assign dbg_pri = (state_q == DBG_PRI);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port DMEM arbiter between the CPU MEM stage and a debug/loader master,
// with one-cycle read-data return routed to the issuing master.
module dmem_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16,
   parameter int MAX_WAIT   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic                  cpu_stall,
   output logic                  cpu_rvalid,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   input  logic                  dbg_req,
   input  logic                  dbg_we,
   input  logic [ADDR_WIDTH-1:0] dbg_addr,
   input  logic [DATA_WIDTH-1:0] dbg_wdata,
   output logic                  dbg_gnt,
   output logic                  dbg_rvalid,
   output logic [DATA_WIDTH-1:0] dbg_rdata,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);
   import dmem_arb_pkg::*;

   logic   dbg_pri;
   logic   cpu_win;
   logic   dbg_win;
   owner_t rd_owner_p1;

   arb_starve_ctr #(
      .MAX_WAIT (MAX_WAIT)
   ) u_starve (
      .clk     (clk),
      .reset   (reset),
      .dbg_req (dbg_req),
      .dbg_gnt (dbg_win),
      .dbg_pri (dbg_pri)
   );

   // Stage p0: pick one winner this cycle
   always_comb begin
      cpu_win = 1'b0;
      dbg_win = 1'b0;
      if (dbg_pri) begin
         dbg_win = dbg_req;
         cpu_win = cpu_req && !dbg_req;
      end else begin
         cpu_win = cpu_req;
         dbg_win = dbg_req && !cpu_req;
      end
   end

   always_comb begin
      mem_en    = cpu_win || dbg_win;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (cpu_win) begin
         mem_we    = cpu_we;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end else if (dbg_win) begin
         mem_we    = dbg_we;
         mem_addr  = dbg_addr;
         mem_wdata = dbg_wdata;
      end
   end

   assign cpu_stall = cpu_req && !cpu_win;
   assign dbg_gnt   = dbg_win;

   // Stage p1: remember who owns the read data returning next cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         rd_owner_p1 <= OWN_NONE;
      else if (cpu_win && !cpu_we)
         rd_owner_p1 <= OWN_CPU;
      else if (dbg_win && !dbg_we)
         rd_owner_p1 <= OWN_DBG;
      else
         rd_owner_p1 <= OWN_NONE;
   end

   assign cpu_rvalid = (rd_owner_p1 == OWN_CPU);
   assign dbg_rvalid = (rd_owner_p1 == OWN_DBG);
   assign cpu_rdata  = mem_rdata;
   assign dbg_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a behavioural grant/memory model predicts
// every grant and read return; a separate monitor checks returned reads.
module tb_dmem_arbiter;
   localparam int AW = 8;
   localparam int DW = 16;
   localparam int MW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          cpu_req, cpu_we, dbg_req, dbg_we;
   logic [AW-1:0] cpu_addr, dbg_addr;
   logic [DW-1:0] cpu_wdata, dbg_wdata;
   logic          cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid;
   logic [DW-1:0] cpu_rdata, dbg_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   function automatic logic [DW-1:0] init_val(input int a);
      return DW'((a * 40503) ^ 16'h5a5a);
   endfunction

   // Synchronous single-port DMEM with one-cycle read latency
   logic [DW-1:0] dmem [256];
   bit            dmem_wr [256];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            dmem[mem_addr]    <= mem_wdata;
            dmem_wr[mem_addr] <= 1'b1;
         end else begin
            mem_rdata <= dmem_wr[mem_addr] ? dmem[mem_addr] : init_val(int'(mem_addr));
         end
      end
   end

   // Reference model state
   logic [DW-1:0] ref_mem [256];
   bit            ref_wr  [256];
   bit            m_dbg_pri;
   int            m_deny;
   int            dbg_waited;
   logic          m_cpu_win, m_dbg_win;
   logic          seen_gnt;

   typedef struct {
      int            due;
      logic [DW-1:0] data;
   } exp_t;
   exp_t cpu_q[$];
   exp_t dbg_q[$];

   int n_chk  = 0;
   int n_fail = 0;
   int cur_cyc = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d: got %h expected %h", name, cur_cyc, act, exp);
      end
   endfunction

   function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
      return ref_wr[a] ? ref_mem[a] : init_val(int'(a));
   endfunction

   // Monitor: read returns are checked independently of the stimulus
   always @(negedge clk) begin
      if (cpu_q.size() > 0 && cpu_q[0].due == cur_cyc) begin
         chk("cpu_rvalid", cpu_rvalid, 1);
         chk("cpu_rdata", cpu_rdata, cpu_q[0].data);
         void'(cpu_q.pop_front());
      end else begin
         chk("cpu_rvalid_idle", cpu_rvalid, 0);
      end
      if (dbg_q.size() > 0 && dbg_q[0].due == cur_cyc) begin
         chk("dbg_rvalid", dbg_rvalid, 1);
         chk("dbg_rdata", dbg_rdata, dbg_q[0].data);
         void'(dbg_q.pop_front());
      end else begin
         chk("dbg_rvalid_idle", dbg_rvalid, 0);
      end
   end

   task automatic model_clear();
      m_dbg_pri  = 1'b0;
      m_deny     = 0;
      dbg_waited = 0;
      cpu_q.delete();
      dbg_q.delete();
   endtask

   task automatic step(input logic cr, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                       input logic dr, input logic dw, input logic [AW-1:0] da, input logic [DW-1:0] dd);
      logic          ewe;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      @(posedge clk);
      #1;
      cur_cyc++;
      cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
      dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
      // Who wins: CPU unless debug has earned priority and is asking
      m_cpu_win = cr && (!m_dbg_pri || !dr);
      m_dbg_win = dr && !m_cpu_win;
      ewe = 1'b0; ea = '0; ed = '0;
      if (m_cpu_win) begin ewe = cw; ea = ca; ed = cd; end
      else if (m_dbg_win) begin ewe = dw; ea = da; ed = dd; end
      #3;
      seen_gnt = dbg_gnt;
      chk("mem_en", mem_en, m_cpu_win || m_dbg_win);
      chk("mem_we", mem_we, ewe);
      chk("mem_addr", mem_addr, ea);
      chk("mem_wdata", mem_wdata, ed);
      chk("dbg_gnt", dbg_gnt, m_dbg_win);
      chk("cpu_stall", cpu_stall, cr && !m_cpu_win);
      if (m_cpu_win) begin
         if (cw) begin ref_mem[ca] = cd; ref_wr[ca] = 1'b1; end
         else cpu_q.push_back('{cur_cyc + 1, ref_rd(ca)});
      end
      if (m_dbg_win) begin
         if (dw) begin ref_mem[da] = dd; ref_wr[da] = 1'b1; end
         else dbg_q.push_back('{cur_cyc + 1, ref_rd(da)});
      end
      if (dr) begin
         dbg_waited++;
         if (m_dbg_win) begin
            chk("dbg_wait_bound", dbg_waited <= MW + 1, 1);
            dbg_waited = 0;
         end
      end else begin
         dbg_waited = 0;
      end
      // Priority: MW consecutive denials hand priority to debug until it is served or withdraws
      if (m_dbg_pri) begin
         if (m_dbg_win || !dr) m_dbg_pri = 1'b0;
      end else if (dr && !m_dbg_win) begin
         m_deny++;
         if (m_deny == MW) begin m_dbg_pri = 1'b1; m_deny = 0; end
      end else begin
         m_deny = 0;
      end
   endtask

   task automatic idle();
      step(0, 0, '0, '0, 0, 0, '0, '0);
   endtask

   task automatic do_reset(input int cycles);
      for (int k = 0; k < cycles; k++) begin
         @(posedge clk);
         #1;
         cur_cyc++;
         reset = 1'b0;
         cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
         dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
         model_clear();
         #3;
         chk("rst_mem_en", mem_en, 0);
         chk("rst_cpu_stall", cpu_stall, 0);
         chk("rst_dbg_gnt", dbg_gnt, 0);
         chk("rst_cpu_rvalid", cpu_rvalid, 0);
         chk("rst_dbg_rvalid", dbg_rvalid, 0);
      end
      @(posedge clk);
      #1;
      cur_cyc++;
      reset = 1'b1;
   endtask

   // Hold a debug request until the model grants it; returns the cycle count to grant
   task automatic hold_dbg(input logic cr, input logic dw, input logic [AW-1:0] da,
                           input logic [DW-1:0] dd, output int gnt_cyc);
      gnt_cyc = 0;
      for (int k = 1; k <= 12 && gnt_cyc == 0; k++) begin
         step(cr, 1'b0, AW'(k), '0, 1'b1, dw, da, dd);
         if (seen_gnt) gnt_cyc = k;
      end
      if (gnt_cyc == 0) chk("dbg_grant_timeout", 0, 1);
   endtask

   initial begin
      int            g;
      logic          cr, cw, dr, dw, pend;
      logic [AW-1:0] ca, da;
      logic [DW-1:0] cd, dd;

      reset = 1'b0;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
      for (int i = 0; i < 256; i++) ref_wr[i] = 1'b0;
      model_clear();
      do_reset(2);

      // CPU only: store then load
      step(1, 1, 8'h10, 16'h1234, 0, 0, '0, '0);
      step(1, 0, 8'h10, '0, 0, 0, '0, '0);
      idle();

      // Debug only: write then read
      step(0, 0, '0, '0, 1, 1, 8'h20, 16'hBEEF);
      step(0, 0, '0, '0, 1, 0, 8'h20, '0);
      idle();

      // Contention: CPU busy every cycle, debug read must get in on cycle MW+1
      hold_dbg(1'b1, 1'b0, 8'h05, '0, g);
      chk("contention_gnt_cycle", g, MW + 1);
      step(1, 0, 8'h06, '0, 0, 0, '0, '0);
      step(1, 1, 8'h05, 16'h0A0A, 0, 0, '0, '0);
      idle();

      // Interleaved reads
      step(1, 0, 8'h01, '0, 0, 0, '0, '0);
      step(0, 0, '0, '0, 1, 0, 8'h02, '0);
      idle();

      // Debug withdraw while in debug priority
      for (int k = 0; k < MW; k++) step(1, 0, 8'h30, '0, 1, 0, 8'h07, '0);
      step(1, 0, 8'h31, '0, 0, 0, '0, '0);
      chk("withdraw_no_stall", cpu_stall, 0);
      hold_dbg(1'b1, 1'b0, 8'h07, '0, g);
      chk("withdraw_restart_cycle", g, MW + 1);
      idle();

      // Reset in the cycle after a CPU read grant
      step(1, 0, 8'h33, '0, 0, 0, '0, '0);
      do_reset(2);
      step(1, 0, 8'h10, '0, 0, 0, '0, '0);
      idle();

      // Randomized traffic with small address space to force aliasing
      pend = 1'b0;
      dr = 0; dw = 0; da = '0; dd = '0;
      for (int i = 0; i < 1500; i++) begin
         cr = ($urandom_range(0, 99) < 65);
         cw = 1'($urandom_range(0, 1));
         ca = AW'($urandom_range(0, 15));
         cd = DW'($urandom);
         if (!pend) begin
            dr = ($urandom_range(0, 99) < 40);
            dw = 1'($urandom_range(0, 1));
            da = AW'($urandom_range(0, 15));
            dd = DW'($urandom);
         end else if ($urandom_range(0, 99) < 3) begin
            dr = 1'b0;
         end
         step(cr, cw, ca, cd, dr, dw, da, dd);
         pend = dr && !m_dbg_win;
         if (i == 750) begin
            do_reset(1);
            pend = 1'b0;
         end
      end
      idle();
      idle();
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
